// File: rtl/instr_decode_latch.sv
// rtl/instr_decode_latch.sv - decode-stage skid-buffered instruction latch with MIPS field split
//
// Purpose: holds fetched instructions in a two-entry skid buffer (MAIN + SKID)
// between fetch and decode. Every field output is decoded combinationally
// from MAIN. A flush is available for branch/jump redirect, and a wrapping
// counter tracks delivered instructions.
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   flush                       synchronous discard of held and incoming beats
//   in_valid/in_instr/in_pc     fetch side beat
//   in_ready                    registered, high unless both entries are full
//   out_valid/out_ready         decode side handshake
//   out_instr/out_pc            raw held instruction and its PC
//   opcode..jaddr               MIPS fields of out_instr (imm feeds sign_extend)
//   is_rtype                    opcode == 0 while out_valid
//   dlv_count                   completed output transfers, wraps
module instr_decode_latch #(
    parameter int          PC_W         = 32,
    parameter logic [31:0] BUBBLE_INSTR = 32'h0,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [PC_W-1:0]  out_pc,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      imm,
    output logic [25:0]      jaddr,
    output logic             is_rtype,
    output logic [CNT_W-1:0] dlv_count
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      main_instr_q, main_instr_d;
    logic [PC_W-1:0]  main_pc_q, main_pc_d;
    logic [31:0]      skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_ready_q;

    logic accept;
    logic deliver;

    assign accept  = in_valid & in_ready_q;
    assign deliver = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        // A deliver in a flush cycle still counts: downstream consumed it.
        cnt_d        = deliver ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;

        if (flush) begin
            state_d      = ST_EMPTY;
            main_instr_d = BUBBLE_INSTR;
            main_pc_d    = '0;
            skid_instr_d = '0;
            skid_pc_d    = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                    end
                end
                ST_ONE: begin
                    if (accept && deliver) begin
                        main_instr_d = in_instr;
                        main_pc_d    = in_pc;
                    end else if (accept) begin
                        state_d      = ST_FULL;
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                    end else if (deliver) begin
                        state_d      = ST_EMPTY;
                        main_instr_d = BUBBLE_INSTR;
                        main_pc_d    = '0;
                    end
                end
                ST_FULL: begin
                    if (deliver) begin
                        state_d      = ST_ONE;
                        main_instr_d = skid_instr_q;
                        main_pc_d    = skid_pc_q;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_instr_d = BUBBLE_INSTR;
                    main_pc_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            main_instr_q <= BUBBLE_INSTR;
            main_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            cnt_q        <= cnt_d;
            // Registered from next state so out_ready never reaches in_ready combinationally.
            in_ready_q   <= (state_d != ST_FULL);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_instr = main_instr_q;
    assign out_pc    = main_pc_q;
    assign opcode    = main_instr_q[31:26];
    assign rs        = main_instr_q[25:21];
    assign rt        = main_instr_q[20:16];
    assign rd        = main_instr_q[15:11];
    assign shamt     = main_instr_q[10:6];
    assign funct     = main_instr_q[5:0];
    assign imm       = main_instr_q[15:0];
    assign jaddr     = main_instr_q[25:0];
    assign is_rtype  = out_valid && (main_instr_q[31:26] == 6'b0);
    assign dlv_count = cnt_q;

endmodule

// File: tb/tb_instr_decode_latch.sv
// tb/tb_instr_decode_latch.sv - directed self-checking bench for instr_decode_latch
module tb_instr_decode_latch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset4 = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [31:0] in_pc = 32'h0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, is_rtype;
    logic [31:0] out_instr, out_pc;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] jaddr;
    logic [15:0] dlv_count;

    logic        in_ready4, out_valid4, is_rtype4;
    logic [31:0] out_instr4, out_pc4;
    logic [5:0]  opcode4, funct4;
    logic [4:0]  rs4, rt4, rd4, shamt4;
    logic [15:0] imm4;
    logic [25:0] jaddr4;
    logic [3:0]  dlv_count4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_decode_latch u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .jaddr(jaddr), .is_rtype(is_rtype), .dlv_count(dlv_count)
    );

    instr_decode_latch #(.CNT_W(4)) u_dut_cnt4 (
        .clk(clk), .reset(reset4), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4), .out_pc(out_pc4),
        .opcode(opcode4), .rs(rs4), .rt(rt4), .rd(rd4), .shamt(shamt4), .funct(funct4),
        .imm(imm4), .jaddr(jaddr4), .is_rtype(is_rtype4), .dlv_count(dlv_count4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_imm", imm, 0);
        check("rst_instr", out_instr, 0);
        check("rst_is_rtype", is_rtype, 0);
        check("rst_dlv", dlv_count, 0);
        step();
        reset = 1'b0;

        // Single beat: addi $t0,$zero,-4
        in_valid = 1; in_instr = 32'h2008FFFC; in_pc = 32'h400; out_ready = 1;
        step();
        check("sb_opcode", opcode, 6'd8);
        check("sb_rs", rs, 0);
        check("sb_rt", rt, 8);
        check("sb_imm", imm, 16'hFFFC);
        check("sb_pc", out_pc, 32'h400);
        check("sb_valid", out_valid, 1);
        check("sb_rtype", is_rtype, 0);
        in_valid = 0;
        step();
        check("sb_dlv", dlv_count, 1);
        check("sb_drained", out_valid, 0);

        // Backpressure: A, B, C back-to-back with out_ready low
        out_ready = 0; in_valid = 1; in_instr = 32'hA0A0A0A0; in_pc = 32'h10;
        step();
        check("bp_A_held", out_instr, 32'hA0A0A0A0);
        check("bp_ready_one", in_ready, 1);
        in_instr = 32'hB0B0B0B0; in_pc = 32'h14;
        step();
        check("bp_A_still", out_instr, 32'hA0A0A0A0);
        check("bp_ready_full", in_ready, 0);
        in_instr = 32'hC0C0C0C0; in_pc = 32'h18;
        step();
        check("bp_hold_instr", out_instr, 32'hA0A0A0A0);
        check("bp_hold_pc", out_pc, 32'h10);
        check("bp_C_refused", in_ready, 0);
        out_ready = 1;
        step();
        check("bp_B_out", out_instr, 32'hB0B0B0B0);
        check("bp_dlv2", dlv_count, 2);
        check("bp_ready_back", in_ready, 1);
        step();
        check("bp_C_out", out_instr, 32'hC0C0C0C0);
        check("bp_C_pc", out_pc, 32'h18);
        check("bp_dlv3", dlv_count, 3);
        in_valid = 0;
        step();
        check("bp_dlv4", dlv_count, 4);
        check("bp_empty", out_valid, 0);

        // Flush while FULL (no deliver): count unchanged, held beats gone
        out_ready = 0; in_valid = 1; in_instr = 32'hD0D0D0D0; in_pc = 32'h20;
        step();
        in_instr = 32'hE0E0E0E0; in_pc = 32'h24;
        step();
        check("fl_full", in_ready, 0);
        flush = 1; in_instr = 32'hF0F0F0F0; in_pc = 32'h28;
        step();
        check("fl_valid", out_valid, 0);
        check("fl_ready", in_ready, 1);
        check("fl_bubble", out_instr, 0);
        check("fl_dlv", dlv_count, 4);
        flush = 0; in_valid = 0; out_ready = 1;
        step();
        check("fl_no_ghost", out_valid, 0);

        // Flush in ONE with deliver and accept in the same cycle
        out_ready = 0; in_valid = 1; in_instr = 32'h11111111; in_pc = 32'h30;
        step();
        flush = 1; out_ready = 1; in_instr = 32'h22222222; in_pc = 32'h34;
        step();
        check("fd_valid", out_valid, 0);
        check("fd_dlv", dlv_count, 5);
        flush = 0; in_valid = 0;
        step();
        check("fd_dropped", out_valid, 0);
        check("fd_dlv_same", dlv_count, 5);

        // Stream of R-type add $t0,$t1,$t2
        in_valid = 1; out_ready = 1; in_instr = 32'h012A4020;
        for (int i = 0; i < 20; i++) begin
            in_pc = 32'h1000 + 32'(4 * i);
            step();
            check("st_pc", out_pc, 32'h1000 + 32'(4 * i));
            check("st_ready", in_ready, 1);
            check("st_valid", out_valid, 1);
        end
        check("st_rs", rs, 9);
        check("st_rt", rt, 10);
        check("st_rd", rd, 8);
        check("st_shamt", shamt, 0);
        check("st_funct", funct, 6'h20);
        check("st_rtype", is_rtype, 1);
        check("st_dlv_mid", dlv_count, 24);
        in_valid = 0;
        step();
        check("st_dlv", dlv_count, 25);

        // Counter wrap on the CNT_W=4 instance: 17 delivers
        reset4 = 0;
        in_valid = 1; in_instr = 32'h00000000;
        for (int i = 0; i < 17; i++) begin
            in_pc = 32'h2000 + 32'(4 * i);
            step();
        end
        check("wr_after16", dlv_count4, 0);
        in_valid = 0;
        step();
        check("wr_after17", dlv_count4, 1);
        check("wr_main_cnt", dlv_count, 42);

        // Async reset mid-cycle while holding a beat
        out_ready = 0; in_valid = 1; in_instr = 32'h3C01ABCD; in_pc = 32'h40;
        step();
        check("ar_loaded", out_valid, 1);
        #2 reset = 1;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_ready", in_ready, 1);
        check("ar_imm", imm, 0);
        check("ar_dlv", dlv_count, 0);
        in_valid = 0;
        step();
        reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
